// File: rtl/mem_trans_stage_if.sv
// mem_trans_stage_if: request, translation and cache-side bus of the
// memory translation stage.
//   in_*  : upstream request channel (valid/ready)
//   at_*  : translation block lookup (vtag out, results back, same cycle)
//   out_* : registered request channel towards the cache (valid/ready)
// Modports: slave = the stage itself, master = the surrounding environment.
interface mem_trans_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_vaddr;
    logic [1:0]  in_op;
    logic [1:0]  in_size;
    logic [7:0]  in_tag;

    logic [19:0] at_vtag;
    logic [19:0] at_ptag;
    logic [1:0]  at_mat;
    logic        at_page_fault;
    logic        at_page_invalid;
    logic        at_page_dirty;
    logic        at_plv_fault;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_paddr;
    logic [1:0]  out_mat;
    logic        out_uncached;
    logic [1:0]  out_op;
    logic [1:0]  out_size;
    logic [7:0]  out_tag;
    logic        out_excp;
    logic [5:0]  out_ecode;
    logic [31:0] out_badv;

    modport slave (
        input  in_valid, in_vaddr, in_op, in_size, in_tag,
        output in_ready,
        output at_vtag,
        input  at_ptag, at_mat, at_page_fault, at_page_invalid, at_page_dirty, at_plv_fault,
        output out_valid, out_paddr, out_mat, out_uncached, out_op, out_size, out_tag,
        output out_excp, out_ecode, out_badv,
        input  out_ready
    );

    modport master (
        output in_valid, in_vaddr, in_op, in_size, in_tag,
        input  in_ready,
        input  at_vtag,
        output at_ptag, at_mat, at_page_fault, at_page_invalid, at_page_dirty, at_plv_fault,
        input  out_valid, out_paddr, out_mat, out_uncached, out_op, out_size, out_tag,
        input  out_excp, out_ecode, out_badv,
        output out_ready
    );
endinterface

// File: rtl/mem_trans_stage.sv
// mem_trans_stage: translation stage between issue and the cache request port.
// Looks up the virtual tag, classifies the access into a LoongArch exception
// or a physical request, and registers it behind a valid/ready handshake with
// a 2-entry skid buffer (main + skid) so in_ready never depends on out_ready.
// Ports:
//   clk, reset (async, active high), flush
//   bus : mem_trans_stage_if.slave (in_*, at_*, out_*)
//   perf_tlbr_cnt, perf_excp_cnt : only with MEM_TRANS_PERF_CNT_EN defined
// Optional macro: MEM_TRANS_PERF_CNT_EN adds saturating exception counters.
module mem_trans_stage (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
`ifdef MEM_TRANS_PERF_CNT_EN
    output logic [31:0]           perf_tlbr_cnt,
    output logic [31:0]           perf_excp_cnt,
`endif
    mem_trans_stage_if.slave      bus
);
    typedef struct packed {
        logic [31:0] paddr;
        logic [1:0]  mat;
        logic        uncached;
        logic [1:0]  op;
        logic [1:0]  size;
        logic [7:0]  tag;
        logic        excp;
        logic [5:0]  ecode;
        logic [31:0] badv;
    } entry_t;

    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    entry_t main_q, skid_q, new_entry;
    logic   main_valid_q, skid_valid_q;
    logic   is_fetch, is_store, misalign;
    logic   in_fire, out_fire, main_free;

    assign bus.at_vtag  = bus.in_vaddr[31:12];
    // Ready comes straight from the skid flag, so cache back-pressure is
    // never combinationally visible upstream.
    assign bus.in_ready = !skid_valid_q;
    assign in_fire      = bus.in_valid && !skid_valid_q;
    assign out_fire     = main_valid_q && bus.out_ready;
    assign main_free    = !main_valid_q || bus.out_ready;

    always_comb begin
        is_fetch = (bus.in_op == 2'd0);
        is_store = (bus.in_op == 2'd2);
        misalign = 1'b0;
        if (is_fetch) begin
            misalign = (bus.in_vaddr[1:0] != 2'b00);
        end else begin
            case (bus.in_size)
                2'd0:    misalign = 1'b0;
                2'd1:    misalign = bus.in_vaddr[0];
                default: misalign = (bus.in_vaddr[1:0] != 2'b00);
            endcase
        end

        new_entry          = '0;
        new_entry.paddr    = {bus.at_ptag, bus.in_vaddr[11:0]};
        new_entry.mat      = bus.at_mat;
        new_entry.uncached = (bus.at_mat == 2'd0);
        new_entry.op       = bus.in_op;
        new_entry.size     = bus.in_size;
        new_entry.tag      = bus.in_tag;
        new_entry.badv     = bus.in_vaddr;
        new_entry.excp     = 1'b1;

        // Priority order: alignment, TLB miss, invalid page, privilege, dirty.
        // op 3 falls through to the load codes.
        if (misalign) begin
            new_entry.ecode = is_fetch ? ECODE_ADE : ECODE_ALE;
        end else if (bus.at_page_fault) begin
            new_entry.ecode = ECODE_TLBR;
        end else if (bus.at_page_invalid) begin
            new_entry.ecode = is_fetch ? ECODE_PIF : (is_store ? ECODE_PIS : ECODE_PIL);
        end else if (bus.at_plv_fault) begin
            new_entry.ecode = ECODE_PPI;
        end else if (is_store && bus.at_page_dirty) begin
            new_entry.ecode = ECODE_PME;
        end else begin
            new_entry.excp  = 1'b0;
            new_entry.ecode = 6'h00;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (flush) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                main_q       <= skid_q;
                main_valid_q <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (in_fire) begin
                main_q       <= new_entry;
                main_valid_q <= 1'b1;
            end else begin
                main_valid_q <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q       <= new_entry;
            skid_valid_q <= 1'b1;
        end
    end

    assign bus.out_valid    = main_valid_q;
    assign bus.out_paddr    = main_q.paddr;
    assign bus.out_mat      = main_q.mat;
    assign bus.out_uncached = main_q.uncached;
    assign bus.out_op       = main_q.op;
    assign bus.out_size     = main_q.size;
    assign bus.out_tag      = main_q.tag;
    assign bus.out_excp     = main_q.excp;
    assign bus.out_ecode    = main_q.ecode;
    assign bus.out_badv     = main_q.badv;

`ifdef MEM_TRANS_PERF_CNT_EN
    logic [31:0] perf_tlbr_cnt_q, perf_excp_cnt_q;

    // Counts retired (transferred) entries; flush does not touch them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_tlbr_cnt_q <= '0;
            perf_excp_cnt_q <= '0;
        end else if (out_fire && main_q.excp) begin
            if (perf_excp_cnt_q != 32'hFFFF_FFFF)
                perf_excp_cnt_q <= perf_excp_cnt_q + 32'd1;
            if (main_q.ecode == ECODE_TLBR && perf_tlbr_cnt_q != 32'hFFFF_FFFF)
                perf_tlbr_cnt_q <= perf_tlbr_cnt_q + 32'd1;
        end
    end

    assign perf_tlbr_cnt = perf_tlbr_cnt_q;
    assign perf_excp_cnt = perf_excp_cnt_q;
`endif
endmodule

// File: tb/tb_mem_trans_stage.sv
module tb_mem_trans_stage;
    logic clk;
    logic reset;
    logic flush;
    int   checks;
    int   errors;

    mem_trans_stage_if bus();

`ifdef MEM_TRANS_PERF_CNT_EN
    logic [31:0] perf_tlbr_cnt, perf_excp_cnt;
`endif

    mem_trans_stage dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
`ifdef MEM_TRANS_PERF_CNT_EN
        .perf_tlbr_cnt (perf_tlbr_cnt),
        .perf_excp_cnt (perf_excp_cnt),
`endif
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic [31:0] vaddr;
        logic        pf, pi, pd, plv;
        logic [1:0]  mat;
        logic        exp_excp;
        logic [5:0]  exp_ecode;
        logic        exp_unc;
    } cls_vec_t;

    task automatic set_req(input logic [1:0] op, input logic [1:0] size, input logic [31:0] vaddr,
                           input logic [7:0] tag, input logic pf, input logic pi, input logic pd,
                           input logic plv, input logic [19:0] ptag, input logic [1:0] mat);
        bus.in_valid        = 1'b1;
        bus.in_op           = op;
        bus.in_size         = size;
        bus.in_vaddr        = vaddr;
        bus.in_tag          = tag;
        bus.at_page_fault   = pf;
        bus.at_page_invalid = pi;
        bus.at_page_dirty   = pd;
        bus.at_plv_fault    = plv;
        bus.at_ptag         = ptag;
        bus.at_mat          = mat;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
        checks++; if (bus.out_paddr !== 32'h0 || bus.out_tag !== 8'h0 || bus.out_excp !== 1'b0)
            begin errors++; $display("FAIL reset_payload got paddr=%h tag=%h excp=%0b exp=0", bus.out_paddr, bus.out_tag, bus.out_excp); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_load();
        bus.out_ready = 1'b1;
        set_req(2'd1, 2'd2, 32'h1C00_0104, 8'h5A, 0, 0, 0, 0, 20'h00ABC, 2'd1);
        #1;
        checks++; if (bus.at_vtag !== 20'h1C000) begin errors++; $display("FAIL at_vtag got=%h exp=1c000", bus.at_vtag); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL load_out_valid got=%0b exp=1", bus.out_valid); end
        checks++; if (bus.out_paddr !== 32'h00AB_C104) begin errors++; $display("FAIL load_paddr got=%h exp=00abc104", bus.out_paddr); end
        checks++; if (bus.out_excp !== 1'b0 || bus.out_uncached !== 1'b0)
            begin errors++; $display("FAIL load_flags got excp=%0b unc=%0b exp=0/0", bus.out_excp, bus.out_uncached); end
        checks++; if (bus.out_tag !== 8'h5A || bus.out_mat !== 2'd1 || bus.out_op !== 2'd1 || bus.out_size !== 2'd2)
            begin errors++; $display("FAIL load_fields got tag=%h mat=%0d op=%0d size=%0d exp=5a/1/1/2",
                                     bus.out_tag, bus.out_mat, bus.out_op, bus.out_size); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL load_drained got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_classify();
        cls_vec_t v[16];
        v[0]  = '{2'd1, 2'd2, 32'h1C00_0104, 0,0,0,0, 2'd1, 1'b0, 6'h00, 1'b0};
        v[1]  = '{2'd2, 2'd2, 32'h8000_2002, 1,0,0,0, 2'd1, 1'b1, 6'h09, 1'b0};
        v[2]  = '{2'd1, 2'd2, 32'h0000_1000, 1,1,0,0, 2'd1, 1'b1, 6'h3F, 1'b0};
        v[3]  = '{2'd2, 2'd2, 32'h0000_2000, 0,0,1,0, 2'd1, 1'b1, 6'h04, 1'b0};
        v[4]  = '{2'd0, 2'd2, 32'h0000_3000, 0,1,0,0, 2'd1, 1'b1, 6'h03, 1'b0};
        v[5]  = '{2'd0, 2'd0, 32'h0000_3002, 1,0,0,0, 2'd1, 1'b1, 6'h08, 1'b0};
        v[6]  = '{2'd1, 2'd1, 32'h0000_4001, 0,0,0,0, 2'd1, 1'b1, 6'h09, 1'b0};
        v[7]  = '{2'd1, 2'd0, 32'h0000_4003, 0,0,0,0, 2'd1, 1'b0, 6'h00, 1'b0};
        v[8]  = '{2'd1, 2'd1, 32'h0000_4002, 0,1,0,0, 2'd1, 1'b1, 6'h01, 1'b0};
        v[9]  = '{2'd2, 2'd3, 32'h0000_5004, 0,1,0,0, 2'd1, 1'b1, 6'h02, 1'b0};
        v[10] = '{2'd1, 2'd2, 32'h0000_6000, 0,0,1,1, 2'd1, 1'b1, 6'h07, 1'b0};
        v[11] = '{2'd1, 2'd2, 32'h0000_7000, 0,0,1,0, 2'd1, 1'b0, 6'h00, 1'b0};
        v[12] = '{2'd3, 2'd2, 32'h0000_8000, 0,1,0,0, 2'd1, 1'b1, 6'h01, 1'b0};
        v[13] = '{2'd1, 2'd2, 32'h0000_9000, 0,0,0,0, 2'd0, 1'b0, 6'h00, 1'b1};
        v[14] = '{2'd2, 2'd1, 32'h0000_A001, 1,0,0,0, 2'd1, 1'b1, 6'h09, 1'b0};
        v[15] = '{2'd2, 2'd2, 32'h0000_B000, 0,0,1,1, 2'd1, 1'b1, 6'h07, 1'b0};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_req(v[i].op, v[i].size, v[i].vaddr, 8'(i), v[i].pf, v[i].pi, v[i].pd, v[i].plv, 20'h12345, v[i].mat);
            @(negedge clk);
            bus.in_valid = 1'b0;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 8'(i))
                begin errors++; $display("FAIL cls%0d_valid got v=%0b tag=%h exp=1/%h", i, bus.out_valid, bus.out_tag, 8'(i)); end
            checks++; if (bus.out_excp !== v[i].exp_excp || bus.out_ecode !== v[i].exp_ecode)
                begin errors++; $display("FAIL cls%0d_ecode got excp=%0b ecode=%h exp=%0b/%h", i, bus.out_excp, bus.out_ecode, v[i].exp_excp, v[i].exp_ecode); end
            checks++; if (bus.out_badv !== v[i].vaddr || bus.out_uncached !== v[i].exp_unc || bus.out_op !== v[i].op)
                begin errors++; $display("FAIL cls%0d_fields got badv=%h unc=%0b op=%0d exp=%h/%0b/%0d", i, bus.out_badv, bus.out_uncached, bus.out_op, v[i].vaddr, v[i].exp_unc, v[i].op); end
        end
        @(negedge clk);
    endtask

    task automatic test_throughput();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_req(2'd1, 2'd2, 32'h0001_0000 + 32'(i * 4), 8'(8'h40 + i), 0, 0, 0, 0, 20'h00001, 2'd1);
            @(negedge clk);
            checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_tag !== 8'(8'h40 + i))
                begin errors++; $display("FAIL thru%0d got rdy=%0b v=%0b tag=%h exp=1/1/%h", i, bus.in_ready, bus.out_valid, bus.out_tag, 8'(8'h40 + i)); end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] got[$];
        logic       clr;
        bus.out_ready = 1'b0;
        set_req(2'd1, 2'd2, 32'h0002_0000, 8'd1, 0, 0, 0, 0, 20'h00002, 2'd1);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1 || bus.out_tag !== 8'd1)
            begin errors++; $display("FAIL b2b_first got rdy=%0b tag=%h exp=1/01", bus.in_ready, bus.out_tag); end
        bus.in_tag = 8'd2;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall got rdy=%0b exp=0", bus.in_ready); end
        bus.in_tag = 8'd3;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_tag !== 8'd1)
            begin errors++; $display("FAIL b2b_hold got rdy=%0b v=%0b tag=%h exp=0/1/01", bus.in_ready, bus.out_valid, bus.out_tag); end
        bus.out_ready = 1'b1;
        clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (clr) bus.in_valid = 1'b0;
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_tag);
            clr = bus.in_valid && bus.in_ready;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++; if (got[i] !== 8'(i + 1)) begin errors++; $display("FAIL b2b_order%0d got=%h exp=%h", i, got[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        set_req(2'd1, 2'd2, 32'h0003_0000, 8'h10, 0, 0, 0, 0, 20'h00003, 2'd1);
        @(negedge clk);
        bus.in_tag = 8'h11;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_full got rdy=%0b exp=0", bus.in_ready); end
        bus.in_tag = 8'h12;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            begin errors++; $display("FAIL flush_full_clear got v=%0b rdy=%0b exp=0/1", bus.out_valid, bus.in_ready); end
        // Flush while in_ready is high: the same-cycle input must be dropped.
        set_req(2'd1, 2'd2, 32'h0003_0004, 8'h13, 0, 0, 0, 0, 20'h00003, 2'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got v=%0b tag=%h exp=0", bus.out_valid, bus.out_tag); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got v=%0b tag=%h exp=0", bus.out_valid, bus.out_tag); end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        set_req(2'd1, 2'd2, 32'h0004_0000, 8'h20, 0, 0, 0, 0, 20'h00004, 2'd1);
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_tag !== 8'h0)
            begin errors++; $display("FAIL async_reset got v=%0b rdy=%0b tag=%h exp=0/1/00", bus.out_valid, bus.in_ready, bus.out_tag); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

`ifdef MEM_TRANS_PERF_CNT_EN
    task automatic test_perf();
        bus.out_ready = 1'b1;
        set_req(2'd1, 2'd2, 32'h0005_0000, 8'h30, 1, 0, 0, 0, 20'h5, 2'd1); @(negedge clk);
        set_req(2'd1, 2'd2, 32'h0005_0004, 8'h31, 0, 0, 0, 0, 20'h5, 2'd1); @(negedge clk);
        set_req(2'd1, 2'd2, 32'h0005_0008, 8'h32, 1, 0, 0, 0, 20'h5, 2'd1); @(negedge clk);
        set_req(2'd1, 2'd2, 32'h0005_000C, 8'h33, 0, 1, 0, 0, 20'h5, 2'd1); @(negedge clk);
        set_req(2'd1, 2'd2, 32'h0005_0010, 8'h34, 0, 0, 0, 0, 20'h5, 2'd1); @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (perf_tlbr_cnt !== 32'd2 || perf_excp_cnt !== 32'd3)
            begin errors++; $display("FAIL perf_counts got tlbr=%0d excp=%0d exp=2/3", perf_tlbr_cnt, perf_excp_cnt); end
        force dut.perf_tlbr_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.perf_tlbr_cnt_q;
        set_req(2'd1, 2'd2, 32'h0005_0014, 8'h35, 1, 0, 0, 0, 20'h5, 2'd1); @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (perf_tlbr_cnt !== 32'hFFFF_FFFF || perf_excp_cnt !== 32'd4)
            begin errors++; $display("FAIL perf_saturate got tlbr=%h excp=%0d exp=ffffffff/4", perf_tlbr_cnt, perf_excp_cnt); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        flush  = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_req(2'd0, 2'd0, 32'h0, 8'h0, 0, 0, 0, 0, 20'h0, 2'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_load();
        test_classify();
        test_throughput();
        test_back_to_back();
        test_flush();
        test_async_reset();
`ifdef MEM_TRANS_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_trans_stage.md
Name: mem_trans_stage

Overview:
- Pipeline stage between the address-generation/issue logic and the cache request port.
- Drives the virtual tag into the address-translation block and samples its combinational results in the same cycle.
- Classifies the access into a LoongArch exception or a physical request, and registers the outcome.
- Uses a valid/ready handshake with a 2-entry skid buffer so that cache back-pressure never forms a combinational ready path to upstream.

Parameters:
- None.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  discards all held and incoming entries this cycle.
- in_valid  in  1  upstream request valid.
- in_ready  out  1  stage can accept a request.
- in_vaddr  in  32  virtual address.
- in_op  in  2  access type: 0 = fetch, 1 = load, 2 = store, 3 = reserved (treated as load).
- in_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = word.
- in_tag  in  8  opaque ROB/instruction tag, passed through.
- at_vtag  out  20  equals in_vaddr[31:12]; drives the translation block.
- at_ptag  in  20  translated physical tag.
- at_mat  in  2  memory access type.
- at_page_fault  in  1  TLB miss.
- at_page_invalid  in  1  TLB hit but V = 0.
- at_page_dirty  in  1  set when the D bit is 0; the name is kept for codebase consistency.
- at_plv_fault  in  1  privilege violation.
- out_valid  out  1  registered request valid.
- out_ready  in  1  cache/consumer accepts.
- out_paddr  out  32  {ptag, vaddr[11:0]}.
- out_mat  out  2  registered MAT.
- out_uncached  out  1  set when out_mat == 0.
- out_op, out_size, out_tag  out  2/2/8  pass-through fields.
- out_excp  out  1  access raised an exception; the cache must not perform it.
- out_ecode  out  6  exception code.
- out_badv  out  32  faulting virtual address; equals vaddr.

Behaviour:
- Reset: out_valid = 0, skid_valid = 0, in_ready = 1. All payload registers reset to 0.
- Handshake:
  - in_ready = !skid_valid, driven from a register only.
  - Transfer occurs when in_valid && in_ready; out transfer when out_valid && out_ready.
  - Main register (out_*) is the head; the skid register holds one overflow entry.
- Accept rules:
  - On an in transfer with the main register empty, or freeing this cycle with skid empty, the entry loads into main.
  - If main is occupied and not draining, the entry loads into skid.
  - When main drains and skid is full, skid moves into main in the same cycle and in_ready rises the next cycle.
- Latency:
  - 1 cycle from accept to out_valid when empty.
  - Throughput 1 per cycle while out_ready = 1.
- Classification (combinational, at accept time), first match wins:
  1. ALE (0x09): misaligned, i.e. size 1 with vaddr[0] != 0, or size 2/3 with vaddr[1:0] != 0. Fetch checks vaddr[1:0] only; a fetch ALE reports ADE (0x08).
  2. TLBR (0x3F): at_page_fault.
  3. PIF (0x03) for fetch, PIL (0x01) for load, PIS (0x02) for store: at_page_invalid.
  4. PPI (0x07): at_plv_fault.
  5. PME (0x04): store && at_page_dirty.
  6. Otherwise out_excp = 0 and out_ecode = 0.
- Exception entries still flow through the handshake. out_paddr is still registered but its value is don't-care for checking.
- Flush:
  - Clears out_valid and skid_valid next edge.
  - Any in transfer in the same cycle is dropped.
  - in_ready returns to 1 the next cycle.
  - Flush has priority over every simultaneous event.
- Reset mid-transfer aborts immediately, asynchronously.
- Payload stability: out_* payload stays stable while out_valid && !out_ready.

Optional Feature:
- Macro: MEM_TRANS_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_tlbr_cnt[31:0] and perf_excp_cnt[31:0], both reset to 0.
  - Each increments on an out transfer of an entry with ecode 0x3F, or with any exception, respectively.
  - Both saturate at 0xFFFFFFFF and are unaffected by flush.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Load, vaddr 0x1C00_0104, size 2, no faults, at_ptag 0x00ABC, at_mat 1, out_ready = 1:
  - next cycle out_valid = 1, out_paddr = 0x00AB_C104, out_excp = 0, out_uncached = 0.
- Store, vaddr 0x8000_2002, size 2: out_excp = 1, ecode 0x09, badv 0x8000_2002, even with at_page_fault = 1 (ALE wins).
- Load with at_page_fault = 1 and at_page_invalid = 1: ecode 0x3F. Store with only at_page_dirty = 1: ecode 0x04. Fetch with only at_page_invalid: ecode 0x03.
- out_ready = 0, 3 back-to-back in_valid entries:
  - entries 1–2 accepted; in_ready = 0 from cycle 2.
  - out_ready = 1 thereafter: tags emerge in order 1, 2, 3 with no loss or duplication.
- Main and skid full, flush = 1 with in_valid = 1: next cycle out_valid = 0 and in_ready = 1; the flushed-cycle input never appears.
- MEM_TRANS_PERF_CNT_EN defined, 5 transfers with 2 TLBR and 1 PIL: perf_tlbr_cnt = 2, perf_excp_cnt = 3. Counter preloaded to 0xFFFFFFFF (force) stays at 0xFFFFFFFF after one further TLBR.
